// File: rtl/alu_issue_ctrl.sv
// Initiator for the 32-bit ALU: issues one op, holds operands for a settle window,
// then captures the result and flags and returns them. Define ALU_OVF_TRAP_EN to enable overflow trapping.
module alu_issue_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_fs,
  input  logic [31:0] req_s,
  input  logic [31:0] req_t,
  input  logic        req_hilo_we,
  output logic [31:0] alu_s,
  output logic [31:0] alu_t,
  output logic [4:0]  alu_fs,
  input  logic [31:0] alu_y_hi,
  input  logic [31:0] alu_y_lo,
  input  logic        alu_c,
  input  logic        alu_v,
  input  logic        alu_n,
  input  logic        alu_z,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_y_lo,
  output logic [31:0] rsp_y_hi,
  output logic [3:0]  rsp_flags,
  output logic        rsp_illegal,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q
`ifdef ALU_OVF_TRAP_EN
  ,
  output logic        ovf_trap
`endif
);

  localparam logic [4:0] FS_ZEROES  = 5'h13;
  localparam logic [4:0] FS_ADD     = 5'h02;
  localparam logic [4:0] FS_SUB     = 5'h04;
  localparam logic [4:0] FS_ILLEGAL = 5'h1A;

  // A zero settle window would capture before the ALU has seen the operands.
  localparam int unsigned      SETTLE_EFF = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(SETTLE_EFF - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e            state_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [31:0]       s_q;
  logic [31:0]       t_q;
  logic [4:0]        fs_q;
  logic              we_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       y_lo_q;
  logic [31:0]       y_hi_q;
  logic [3:0]        flags_q;
  logic              illegal_q;
  logic              hilo_block_d;

`ifdef ALU_OVF_TRAP_EN
  logic ovf_q;
  assign hilo_block_d = alu_v & ((fs_q == FS_ADD) | (fs_q == FS_SUB));
  assign ovf_trap     = ovf_q;
`else
  assign hilo_block_d = 1'b0;
`endif

  // NOTE: every datapath register is reset because each output has a defined reset
  // value; a reset during WAIT must also drop the pending HI/LO write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      s_q         <= '0;
      t_q         <= '0;
      fs_q        <= FS_ZEROES;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      y_lo_q      <= '0;
      y_hi_q      <= '0;
      flags_q     <= '0;
      illegal_q   <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
`ifdef ALU_OVF_TRAP_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            s_q         <= req_s;
            t_q         <= req_t;
            fs_q        <= req_fs;
            we_q        <= req_hilo_we;
            cnt_q       <= CNT_LOAD;
            req_ready_q <= 1'b0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            y_lo_q      <= alu_y_lo;
            y_hi_q      <= alu_y_hi;
            flags_q     <= {alu_c, alu_v, alu_n, alu_z};
            illegal_q   <= (fs_q >= FS_ILLEGAL);
`ifdef ALU_OVF_TRAP_EN
            ovf_q       <= hilo_block_d;
`endif
            if (we_q && !hilo_block_d) begin
              hi_q <= alu_y_hi;
              lo_q <= alu_y_lo;
            end
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign alu_s       = s_q;
  assign alu_t       = t_q;
  assign alu_fs      = fs_q;
  assign rsp_y_lo    = y_lo_q;
  assign rsp_y_hi    = y_hi_q;
  assign rsp_flags   = flags_q;
  assign rsp_illegal = illegal_q;

endmodule
